// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises select+payload frames into RAM command
// words and serialises the RAM read byte back onto MISO.
module spi_slave_if #(
  parameter int unsigned RX_WIDTH = 10,
  parameter int unsigned TX_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic [RX_WIDTH-1:0] rx_data,
  output logic                rx_valid,
  input  logic [TX_WIDTH-1:0] tx_data,
  input  logic                tx_valid
);

  localparam int unsigned RX_CNT_W = $clog2(RX_WIDTH);
  localparam int unsigned TX_CNT_W = $clog2(TX_WIDTH);
  localparam int unsigned SHIFT_W  = RX_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                state;
  logic [RX_CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0]    rx_shift;
  logic                  rx_done;
  logic                  rd_addr_seen;
  logic [TX_WIDTH-1:0]   tx_shift;
  logic [TX_CNT_W-1:0]   tx_cnt;
  logic                  tx_busy;
  logic                  tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx_shift     <= '0;
      rx_done      <= 1'b0;
      rd_addr_seen <= 1'b0;
      tx_shift     <= '0;
      tx_cnt       <= '0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Slave deselect ends the frame from any active state and drops pending transmit.
      if (state != IDLE && ss_n) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        rx_done  <= 1'b0;
        tx_shift <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b0;
        tx_done  <= 1'b0;
        miso     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!ss_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!mosi)             state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!rx_done) begin
              rx_shift <= SHIFT_W'({rx_shift, mosi});
              if (bit_cnt == RX_CNT_W'(RX_WIDTH - 1)) begin
                rx_data  <= {rx_shift, mosi};
                rx_valid <= 1'b1;
                rx_done  <= 1'b1;
                if (state == READ_ADD)       rd_addr_seen <= 1'b1;
                else if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + RX_CNT_W'(1);
              end
            end else if (state == READ_DATA) begin
              // Latch the first valid read byte once, then shift it out MSB first.
              if (tx_busy) begin
                miso     <= tx_shift[TX_WIDTH-1];
                tx_shift <= {tx_shift[TX_WIDTH-2:0], 1'b0};
                if (tx_cnt == TX_CNT_W'(TX_WIDTH - 1)) begin
                  tx_busy <= 1'b0;
                  tx_done <= 1'b1;
                end else begin
                  tx_cnt <= tx_cnt + TX_CNT_W'(1);
                end
              end else begin
                miso <= 1'b0;
                if (!tx_done && tx_valid) begin
                  tx_shift <= tx_data;
                  tx_busy  <= 1'b1;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
